// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in, parallel-out frame assembler.
package sipo_pkg;

  localparam int SIPO_WIDTH_DEFAULT = 35;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FULL  = 2'd3
  } state_t;

endpackage

// File: rtl/sipo_frame.sv
// Serial-in, parallel-out frame assembler with a one-frame output holding slot.
// Define SIPO_FRAME_PARITY_EN to add a trailing parity beat and the parity_err output.
module sipo_frame
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b0
`ifdef SIPO_FRAME_PARITY_EN
  , parameter bit ODD_PARITY = 1'b0
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sync_clr,
  input  logic                       in_valid,
  input  logic                       in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
`ifdef SIPO_FRAME_PARITY_EN
  , output logic                     parity_err
`endif
);

  localparam int             CW       = $clog2(WIDTH+1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH-1);
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef SIPO_FRAME_PARITY_EN
  localparam state_t DONE_STATE = PAR;
`else
  localparam state_t DONE_STATE = FULL;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             beat;
  int               place_idx;
  logic [WIDTH-1:0] place_mask;
`ifdef SIPO_FRAME_PARITY_EN
  logic             pbit_q;
  logic             perr_q;
`endif

  assign in_ready  = (state_q != FULL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign bit_cnt   = cnt_q;
`ifdef SIPO_FRAME_PARITY_EN
  assign parity_err = perr_q;
`endif

  // The bit counter doubles as the write pointer, mirrored for MSB-first streams.
  always_comb begin
    beat       = in_valid && in_ready;
    place_idx  = MSB_FIRST ? (WIDTH - 1 - int'(cnt_q)) : int'(cnt_q);
    place_mask = ONE << place_idx;
    shift_d    = in_data ? (shift_q | place_mask) : (shift_q & ~place_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef SIPO_FRAME_PARITY_EN
      pbit_q      <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (sync_clr) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (beat) begin
              shift_q <= shift_d;
              cnt_q   <= CW'(1);
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (beat) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CW'(1);
              if (cnt_q == LAST_CNT) begin
                state_q <= DONE_STATE;
              end
            end
          end
          PAR: begin
`ifdef SIPO_FRAME_PARITY_EN
            if (beat) begin
              pbit_q  <= in_data;
              state_q <= FULL;
            end
`else
            state_q <= IDLE;
`endif
          end
          FULL: begin
            // A load here overrides the handshake clear above, so back-to-back frames never gap.
            if (!out_valid_q || out_ready) begin
              out_data_q  <= shift_q;
              out_valid_q <= 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
              perr_q      <= (^{shift_q, pbit_q}) ^ ODD_PARITY;
`endif
              cnt_q       <= '0;
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame.sv
// Directed self-checking bench for sipo_frame: three instances cover 35-bit LSB-first,
// 8-bit MSB-first and 8-bit LSB-first configurations.
module tb_sipo_frame;

  logic clk;
  logic rst_n;
  logic din;
  logic [2:0] vld;
  logic [2:0] clr;
  logic rdyA, rdyB, rdyC;

  logic        irA, ovA;
  logic [34:0] odA;
  logic [5:0]  bcA;
  logic        irB, ovB;
  logic [7:0]  odB;
  logic [3:0]  bcB;
  logic        irC, ovC;
  logic [7:0]  odC;
  logic [3:0]  bcC;
`ifdef SIPO_FRAME_PARITY_EN
  logic        perrA, perrB, perrC;
`endif

  int tests = 0;
  int fails = 0;

  sipo_frame #(.WIDTH(35), .MSB_FIRST(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .sync_clr(clr[0]), .in_valid(vld[0]), .in_data(din),
    .in_ready(irA), .out_valid(ovA), .out_ready(rdyA), .out_data(odA), .bit_cnt(bcA)
`ifdef SIPO_FRAME_PARITY_EN
    , .parity_err(perrA)
`endif
  );

  sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) dutB (
    .clk(clk), .rst_n(rst_n), .sync_clr(clr[1]), .in_valid(vld[1]), .in_data(din),
    .in_ready(irB), .out_valid(ovB), .out_ready(rdyB), .out_data(odB), .bit_cnt(bcB)
`ifdef SIPO_FRAME_PARITY_EN
    , .parity_err(perrB)
`endif
  );

  sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) dutC (
    .clk(clk), .rst_n(rst_n), .sync_clr(clr[2]), .in_valid(vld[2]), .in_data(din),
    .in_ready(irC), .out_valid(ovC), .out_ready(rdyC), .out_data(odC), .bit_cnt(bcC)
`ifdef SIPO_FRAME_PARITY_EN
    , .parity_err(perrC)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic b);
    vld = 3'(1 << k);
    din = b;
    @(posedge clk);
    #1;
    vld = '0;
    din = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendData(input int k, input logic [63:0] d, input int w);
    logic [63:0] tmp;
    tmp = d;
    for (int i = 0; i < w; i++) begin
      applyStimulus(k, tmp[0]);
      tmp = tmp >> 1;
    end
  endtask

  // Under the parity build every frame gets a correct even-parity trailer.
  task automatic sendFrame(input int k, input logic [63:0] d, input int w);
    sendData(k, d, w);
`ifdef SIPO_FRAME_PARITY_EN
    applyStimulus(k, ^d);
`endif
  endtask

  task automatic clearPulse(input int k, input logic b);
    clr = 3'(1 << k);
    vld = 3'(1 << k);
    din = b;
    @(posedge clk);
    #1;
    clr = '0;
    vld = '0;
    din = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;
    vld   = '0;
    clr   = '0;
    rdyA  = 1'b1;
    rdyB  = 1'b1;
    rdyC  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ovA", 64'(ovA), 64'd0);
    checkOutput("rst_bcA", 64'(bcA), 64'd0);
    checkOutput("rst_odA", 64'(odA), 64'd0);
    checkOutput("rst_irA", 64'(irA), 64'd1);
    rst_n = 1'b1;
    idleCycles(1);

    // 35-bit frame, LSB first, slot free
    sendFrame(0, 64'h5_A5A5_A5A5, 35);
    checkOutput("full_ovA", 64'(ovA), 64'd0);
    checkOutput("full_bcA", 64'(bcA), 64'd35);
    checkOutput("full_irA", 64'(irA), 64'd0);
    idleCycles(1);
    checkOutput("lat_ovA", 64'(ovA), 64'd1);
    checkOutput("lat_odA", 64'(odA), 64'h5_A5A5_A5A5);
    checkOutput("lat_bcA", 64'(bcA), 64'd0);
    idleCycles(1);
    checkOutput("drain_ovA", 64'(ovA), 64'd0);

    // 8-bit MSB-first: stream 1,0,1,1,0,0,1,0
    sendFrame(1, 64'h4D, 8);
    idleCycles(1);
    checkOutput("msb_ovB", 64'(ovB), 64'd1);
    checkOutput("msb_odB", 64'(odB), 64'hB2);

    // Backpressure: two frames with out_ready low
    sendFrame(2, 64'h11, 8);
    idleCycles(1);
    checkOutput("bp1_ovC", 64'(ovC), 64'd1);
    checkOutput("bp1_odC", 64'(odC), 64'h11);
    sendFrame(2, 64'h22, 8);
    idleCycles(2);
    checkOutput("bp2_odC", 64'(odC), 64'h11);
    checkOutput("bp2_irC", 64'(irC), 64'd0);
    checkOutput("bp2_ovC", 64'(ovC), 64'd1);
    checkOutput("bp2_bcC", 64'(bcC), 64'd8);
    rdyC = 1'b1;
    idleCycles(1);
    rdyC = 1'b0;
    checkOutput("bp3_odC", 64'(odC), 64'h22);
    checkOutput("bp3_ovC", 64'(ovC), 64'd1);
    checkOutput("bp3_irC", 64'(irC), 64'd1);
    rdyC = 1'b1;
    idleCycles(1);
    checkOutput("bp4_ovC", 64'(ovC), 64'd0);

    // Synchronous abort overrides a same-cycle beat
    sendData(2, 64'h1F, 5);
    checkOutput("clr_pre_bcC", 64'(bcC), 64'd5);
    clearPulse(2, 1'b1);
    checkOutput("clr_bcC", 64'(bcC), 64'd0);
    checkOutput("clr_irC", 64'(irC), 64'd1);
    sendFrame(2, 64'h3C, 8);
    idleCycles(1);
    rdyC = 1'b0;
    checkOutput("clr_odC", 64'(odC), 64'h3C);
    checkOutput("clr_ovC", 64'(ovC), 64'd1);
    sendData(2, 64'h5, 3);
    checkOutput("clr2_pre_bcC", 64'(bcC), 64'd3);
    clearPulse(2, 1'b0);
    checkOutput("clr2_bcC", 64'(bcC), 64'd0);
    checkOutput("clr2_ovC", 64'(ovC), 64'd1);
    checkOutput("clr2_odC", 64'(odC), 64'h3C);
    rdyC = 1'b1;
    idleCycles(1);
    checkOutput("clr3_ovC", 64'(ovC), 64'd0);

    // Asynchronous reset mid-frame
    rdyA = 1'b0;
    sendFrame(0, 64'h1_2345_6789, 35);
    idleCycles(1);
    checkOutput("hold_ovA", 64'(ovA), 64'd1);
    checkOutput("hold_odA", 64'(odA), 64'h1_2345_6789);
    sendData(0, 64'h5_5555, 20);
    checkOutput("mid_bcA", 64'(bcA), 64'd20);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_ovA", 64'(ovA), 64'd0);
    checkOutput("arst_bcA", 64'(bcA), 64'd0);
    checkOutput("arst_odA", 64'(odA), 64'd0);
    #2;
    rst_n = 1'b1;
    idleCycles(1);
    rdyA = 1'b1;
    sendFrame(0, 64'h2_AAAA_5555, 35);
    idleCycles(1);
    checkOutput("post_ovA", 64'(ovA), 64'd1);
    checkOutput("post_odA", 64'(odA), 64'h2_AAAA_5555);

`ifdef SIPO_FRAME_PARITY_EN
    // Even parity: 8'h07 has three ones
    sendData(2, 64'h07, 8);
    applyStimulus(2, 1'b0);
    idleCycles(1);
    checkOutput("par0_odC", 64'(odC), 64'h07);
    checkOutput("par0_perrC", 64'(perrC), 64'd1);
    sendData(2, 64'h07, 8);
    applyStimulus(2, 1'b1);
    idleCycles(1);
    checkOutput("par1_odC", 64'(odC), 64'h07);
    checkOutput("par1_perrC", 64'(perrC), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sipo_frame.md
SIPO_FRAME -- requirements
Module: sipo_frame

Interface
REQ-001 SHALL have parameter WIDTH, default 35, parallel frame width in bits (2..64).
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 = first serial bit lands in bit 0, 1 = first bit lands in bit WIDTH-1.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port sync_clr  input  1  synchronous frame abort; discards partial frame.
REQ-006 SHALL have port in_valid  input  1  serial bit qualifier.
REQ-007 SHALL have port in_data  input  1  serial data bit.
REQ-008 SHALL have port in_ready  output  1  block accepts a serial bit this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a complete frame.
REQ-010 SHALL have port out_ready  input  1  downstream consumes frame.
REQ-011 SHALL have port out_data  output  WIDTH  assembled frame.
REQ-012 SHALL have port bit_cnt  output  $clog2(WIDTH+1)  bits collected in current frame.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PAR, FULL.
REQ-014 SHALL accept a bit only when in_valid && in_ready (a "beat"); no beat, no state change.
REQ-015 IDLE: first beat stores bit, bit_cnt=1, go SHIFT.
REQ-016 SHIFT: each beat stores bit at position bit_cnt (mirrored when MSB_FIRST=1), bit_cnt+1; beat with bit_cnt=WIDTH-1 completes data, go PAR if parity compiled in, else FULL.
REQ-017 FULL: SHALL move frame to out_data and set out_valid when out_valid=0 or out_ready=1 that cycle, then clear bit_cnt to 0 and go IDLE.
REQ-018 in_ready SHALL be 1 in IDLE/SHIFT/PAR, 0 in FULL (no overrun possible).
REQ-019 Latency: out_valid SHALL assert the cycle after the completing beat when output slot free (FULL occupies exactly one cycle).
REQ-020 out_valid SHALL stay 1 and out_data stable until out_ready=1; out_valid && out_ready with no new frame clears out_valid next cycle.
REQ-021 Simultaneous out_ready and FULL transfer SHALL replace out_data with no out_valid gap.
REQ-022 Partial frame collection SHALL continue while out_valid=1 (one frame in output + one assembling).
REQ-023 sync_clr SHALL return to IDLE, bit_cnt=0, drop partial frame; out_valid/out_data untouched; sync_clr overrides a same-cycle beat.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, bit_cnt 0, out_valid 0, out_data 0, parity_err 0, shift register 0.
REQ-025 Reset mid-frame SHALL discard the frame; first beat after release starts a new frame.

Configuration
REQ-026 Macro SIPO_FRAME_PARITY_EN SHALL add state PAR, output port parity_err (1 bit), parameter ODD_PARITY default 0.
REQ-027 With macro: PAR consumes one extra beat as parity bit; parity_err SHALL be loaded with mismatch alongside out_data and held with it; frame still delivered.
REQ-028 Without macro: PAR unreachable/absent, no parity_err port, frame = exactly WIDTH beats.

Structure
REQ-029 Shared package sipo_pkg SHALL hold the state enum typedef and the default WIDTH constant (35).
REQ-030 No sub-module; bit placement logic inline.

Verification
REQ-031 WIDTH=35, MSB_FIRST=0, 35 beats of 35'h5_A5A5_A5A5 LSB first, out_ready=1 -> out_valid one cycle after beat 35, out_data=35'h5_A5A5_A5A5.
REQ-032 WIDTH=8, MSB_FIRST=1, beats 1,0,1,1,0,0,1,0 -> out_data=8'hB2.
REQ-033 WIDTH=8, out_ready=0, send two frames 8'h11 then 8'h22 -> out_data stays 8'h11, in_ready=0 after second frame; out_ready=1 one cycle -> out_data=8'h22, in_ready=1.
REQ-034 WIDTH=8, 5 beats then sync_clr with in_valid=1 -> bit_cnt=0; next 8 beats 8'h3C -> out_data=8'h3C.
REQ-035 rst_n low after 20 beats of 35-bit frame -> out_valid=0, bit_cnt=0 immediately, without waiting for clk.
REQ-036 SIPO_FRAME_PARITY_EN, even parity, 8'h07 with parity bit 0 -> out_data=8'h07, parity_err=1; parity bit 1 -> parity_err=0.
